// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    // funct3 encodings of the M-extension operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } muldiv_state_e;

    localparam int          MULDIV_ITERS = 32;
    localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUOT     = 32'h8000_0000;

    // Divide/remainder operations all have funct3[2] set
    function automatic logic is_div_op(input muldiv_op_e op);
        return op[2];
    endfunction

    // Remainder operations (REM, REMU) have funct3[1] set within the divide group
    function automatic logic is_rem_op(input muldiv_op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One 64-bit register is shared between the shift-add multiplier (product,
// multiplier shifting out of the low word) and the restoring divider
// (remainder in the high word, dividend/quotient in the low word).
//
// Handshake: an operation is accepted in IDLE when START is high and FLUSH is
// low; STALL is asserted from that cycle until the result is ready. DONE is a
// single-cycle pulse in which RESULT is valid; RESULT then holds until the
// next DONE. FLUSH outside IDLE abandons the operation without a DONE.
module ex_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [2:0]  OP,
    input  logic [31:0] OPERAND_A,
    input  logic [31:0] OPERAND_B,
    input  logic        FLUSH,
    output logic        STALL,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT
);

    muldiv_state_e r_state;
    muldiv_state_e w_state_next;

    muldiv_op_e    r_op;
    logic [31:0]   r_b_mag;
    logic          r_neg_q;      // product / quotient must be negated
    logic          r_a_neg;      // remainder must be negated (dividend sign)
    logic [4:0]    r_cnt;
    logic [63:0]   r_acc;
    logic [31:0]   r_result;

    muldiv_op_e    w_op;
    logic          w_a_signed;
    logic          w_b_signed;
    logic          w_a_neg;
    logic          w_b_neg;
    logic [31:0]   w_a_mag;
    logic [31:0]   w_b_mag;
    logic          w_div0;
    logic          w_ovf;
    logic          w_special;
    logic [31:0]   w_special_res;
    logic          w_accept;
    logic          w_last_iter;

    logic [32:0]   w_sum;
    logic [32:0]   w_shift;
    logic [32:0]   w_diff;
    logic [63:0]   w_acc_next;

    logic [63:0]   w_prod;
    logic [31:0]   w_quot;
    logic [31:0]   w_rem;
    logic [31:0]   w_fix_res;

    assign w_op = muldiv_op_e'(OP);

    // Operand signedness and magnitudes; MUL is treated as unsigned on raw operands
    always_comb begin
        w_a_signed = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                     (w_op == OP_DIV)  || (w_op == OP_REM);
        w_b_signed = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
        w_a_neg    = w_a_signed & OPERAND_A[31];
        w_b_neg    = w_b_signed & OPERAND_B[31];
        w_a_mag    = w_a_neg ? (~OPERAND_A + 32'd1) : OPERAND_A;
        w_b_mag    = w_b_neg ? (~OPERAND_B + 32'd1) : OPERAND_B;
    end

    // Divide-by-zero and signed overflow bypass the iteration entirely
    always_comb begin
        w_div0    = is_div_op(w_op) && (OPERAND_B == 32'd0);
        w_ovf     = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                    (OPERAND_A == OVF_QUOT) && (OPERAND_B == 32'hFFFF_FFFF);
        w_special = w_div0 | w_ovf;
        w_special_res = 32'd0;
        if (w_div0) begin
            w_special_res = is_rem_op(w_op) ? OPERAND_A : DIV0_QUOT;
        end else if (w_ovf) begin
            w_special_res = is_rem_op(w_op) ? 32'd0 : OVF_QUOT;
        end
    end

    assign w_accept    = (r_state == ST_IDLE) && START && !FLUSH;
    assign w_last_iter = (r_cnt == 5'(MULDIV_ITERS - 1));

    // One iteration of the shared shift datapath
    always_comb begin
        w_sum   = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_b_mag : 32'd0)};
        w_shift = r_acc[63:31];
        w_diff  = w_shift - {1'b0, r_b_mag};
        if (is_div_op(r_op)) begin
            if (!w_diff[32]) begin
                w_acc_next = {w_diff[31:0], r_acc[30:0], 1'b1};
            end else begin
                w_acc_next = {w_shift[31:0], r_acc[30:0], 1'b0};
            end
        end else begin
            w_acc_next = {w_sum, r_acc[31:1]};
        end
    end

    // Sign correction and result selection after the last iteration
    always_comb begin
        w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
        w_quot = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
        w_rem  = r_a_neg ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
        case (r_op)
            OP_MUL:                      w_fix_res = w_prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[63:32];
            OP_DIV, OP_DIVU:             w_fix_res = w_quot;
            OP_REM, OP_REMU:             w_fix_res = w_rem;
            default:                     w_fix_res = w_prod[31:0];
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and status outputs
    always_comb begin
        w_state_next = r_state;
        STALL        = 1'b0;
        BUSY         = 1'b1;
        DONE         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                BUSY  = 1'b0;
                STALL = w_accept;
                if (w_accept) begin
                    w_state_next = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                STALL = 1'b1;
                if (FLUSH) begin
                    w_state_next = ST_IDLE;
                end else if (w_last_iter) begin
                    w_state_next = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                STALL        = 1'b1;
                w_state_next = FLUSH ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                DONE         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Latch operation, sign flags and divisor magnitude on acceptance
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_op    <= OP_MUL;
            r_b_mag <= 32'd0;
            r_neg_q <= 1'b0;
            r_a_neg <= 1'b0;
        end else if (w_accept) begin
            r_op    <= w_op;
            r_b_mag <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_a_neg <= w_a_neg;
        end
    end

    // Iteration counter and shared accumulator
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= 5'd0;
            r_acc <= 64'd0;
        end else if (w_accept) begin
            r_cnt <= 5'd0;
            r_acc <= {32'd0, w_a_mag};
        end else if (r_state == ST_CALC) begin
            r_cnt <= r_cnt + 5'd1;
            r_acc <= w_acc_next;
        end
    end

    // Result register: special results load on acceptance, normal ones in FIXUP
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_result <= 32'd0;
        end else if (w_accept && w_special) begin
            r_result <= w_special_res;
        end else if ((r_state == ST_FIXUP) && !FLUSH) begin
            r_result <= w_fix_res;
        end
    end

    assign RESULT = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vectors, randomized
// operations against an arithmetic reference model, flush, reset and
// back-to-back issue.
module tb_ex_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [2:0]  OP;
  logic [31:0] OPERAND_A;
  logic [31:0] OPERAND_B;
  logic        FLUSH;
  logic        STALL;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  ex_muldiv_unit dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .OP        (OP),
    .OPERAND_A (OPERAND_A),
    .OPERAND_B (OPERAND_B),
    .FLUSH     (FLUSH),
    .STALL     (STALL),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op[2] && (b == 32'd0)) ||
           (((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    int              ia;
    int              ib;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // ---------------- driver ----------------
  // Issues one operation in the next cycle and waits (bounded) for DONE.
  // lat counts cycles from the accepting cycle to DONE; stalls counts STALL-high cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stalls, output bit got);
    @(posedge CLK); #1;
    START = 1'b1; OP = op; OPERAND_A = a; OPERAND_B = b;
    lat = 0; stalls = 0; got = 1'b0; res = 32'd0;
    #1;
    if (STALL) stalls++;
    for (int i = 1; i <= 100 && !got; i++) begin
      @(posedge CLK); #1;
      START = 1'b0;
      OPERAND_A = $urandom;
      OPERAND_B = $urandom;
      #1;
      if (STALL) stalls++;
      if (DONE) begin
        got = 1'b1;
        lat = i;
        res = RESULT;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1; START = 1'b0; FLUSH = 1'b0; OP = 3'd0; OPERAND_A = 32'd0; OPERAND_B = 32'd0;
    repeat (3) @(negedge CLK);
    total++;
    if (BUSY !== 1'b0 || STALL !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%b stall=%b done=%b result=%h, required 0 0 0 00000000",
               BUSY, STALL, DONE, RESULT);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [12];
    logic [31:0] t_a  [12];
    logic [31:0] t_b  [12];
    logic [31:0] t_e  [12];
    logic [31:0] res;
    int          lat;
    int          stalls;
    int          e_lat;
    bit          got;
    t_op = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    t_a  = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
             32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    t_b  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
             32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    t_e  = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
             32'h7FFFFFFC, 32'h00000001, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    for (int k = 0; k < 12; k++) begin
      e_lat = (k >= 8) ? 1 : 34;
      run_op(t_op[k], t_a[k], t_b[k], res, lat, stalls, got);
      total++;
      if (!got) begin
        bad++;
        $display("FAIL directed_timeout[%0d]: no DONE within 100 cycles, required DONE at %0d", k, e_lat);
      end else begin
        if (res !== t_e[k]) begin
          bad++;
          $display("FAIL directed_result[%0d] op=%0d: got %h, required %h", k, t_op[k], res, t_e[k]);
        end
        total++;
        if (lat !== e_lat) begin
          bad++;
          $display("FAIL directed_latency[%0d]: DONE at N+%0d, required N+%0d", k, lat, e_lat);
        end
        total++;
        if (stalls !== e_lat) begin
          bad++;
          $display("FAIL directed_stall[%0d]: stall cycles %0d, required %0d", k, stalls, e_lat);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] exp_v;
    int          lat;
    int          stalls;
    int          e_lat;
    int          sel;
    bit          got;
    for (int k = 0; k < 40; k++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      exp_q.push_back(ref_model(op, a, b));
      e_lat = is_special(op, a, b) ? 1 : 34;
      run_op(op, a, b, res, lat, stalls, got);
      exp_v = exp_q.pop_front();
      total++;
      if (!got) begin
        bad++;
        $display("FAIL random_timeout[%0d]: no DONE within 100 cycles", k);
      end else begin
        if (res !== exp_v) begin
          bad++;
          $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h, required %h", k, op, a, b, res, exp_v);
        end
        total++;
        if (lat !== e_lat || stalls !== e_lat) begin
          bad++;
          $display("FAIL random_timing[%0d] op=%0d: done at N+%0d stalls %0d, required %0d",
                   k, op, lat, stalls, e_lat);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [5];
    logic [31:0] as  [5];
    logic [31:0] bs  [5];
    logic [31:0] res;
    logic [31:0] exp_v;
    int          lat;
    int          stalls;
    bit          got;
    ops = '{3'd7, 3'd4, 3'd1, 3'd6, 3'd5};
    as  = '{32'd9, 32'h80000000, 32'h12345678, 32'hDEADBEEF, 32'd1000};
    bs  = '{32'd0, 32'hFFFFFFFF, 32'h9ABCDEF0, 32'd0, 32'd33};
    for (int k = 0; k < 5; k++) begin
      exp_v = ref_model(ops[k], as[k], bs[k]);
      run_op(ops[k], as[k], bs[k], res, lat, stalls, got);
      total++;
      if (!got || res !== exp_v || lat !== (is_special(ops[k], as[k], bs[k]) ? 1 : 34)) begin
        bad++;
        $display("FAIL b2b[%0d]: got=%b result %h latency %0d, required %h", k, got, res, lat, exp_v);
      end
    end
    // cycle after DONE: pulse gone, back in IDLE, result held
    @(posedge CLK); #2;
    total++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || RESULT !== exp_v) begin
      bad++;
      $display("FAIL b2b_hold: done=%b busy=%b result=%h, required 0 0 %h", DONE, BUSY, RESULT, exp_v);
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    int          early_done;
    int          lat;
    bit          got;
    prev = RESULT;
    early_done = 0;
    @(posedge CLK); #1;
    START = 1'b1; OP = 3'd4; OPERAND_A = 32'd100; OPERAND_B = 32'd7;
    for (int i = 1; i <= 10; i++) begin
      @(posedge CLK); #1;
      START = 1'b0;
      #1;
      if (DONE) early_done++;
    end
    FLUSH = 1'b1;                       // during cycle N+10
    @(posedge CLK); #1;                 // cycle N+11
    FLUSH = 1'b0;
    START = 1'b1; OP = 3'd0; OPERAND_A = 32'd3; OPERAND_B = 32'd4;
    #1;
    total++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== prev || early_done != 0 || STALL !== 1'b1) begin
      bad++;
      $display("FAIL flush_kill: busy=%b done=%b stall=%b result=%h early_done=%0d, required 0 0 1 %h 0",
               BUSY, DONE, STALL, RESULT, early_done, prev);
    end
    got = 1'b0; lat = 0;
    for (int i = 1; i <= 100 && !got; i++) begin
      @(posedge CLK); #1;
      START = 1'b0;
      #1;
      if (DONE) begin got = 1'b1; lat = i; end
    end
    total++;
    if (!got || lat != 34 || RESULT !== 32'd12) begin
      bad++;
      $display("FAIL flush_reissue: got=%b done at +%0d result %h, required +34 0000000c", got, lat, RESULT);
    end
    // FLUSH wins over START in IDLE
    @(posedge CLK); #1;
    START = 1'b1; FLUSH = 1'b1; OP = 3'd0;
    #1;
    total++;
    if (STALL !== 1'b0) begin
      bad++;
      $display("FAIL flush_priority_stall: stall=%b, required 0", STALL);
    end
    @(posedge CLK); #1;
    START = 1'b0; FLUSH = 1'b0;
    #1;
    total++;
    if (BUSY !== 1'b0) begin
      bad++;
      $display("FAIL flush_priority_busy: busy=%b, required 0", BUSY);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic [31:0] exp_v;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          stalls;
    bit          got;
    @(posedge CLK); #1;
    START = 1'b1; OP = 3'd0; OPERAND_A = 32'd5; OPERAND_B = 32'd6;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      START = 1'b0;
    end
    #2;
    RST = 1'b1;                          // mid-cycle, away from the clock edge
    #1;
    total++;
    if (BUSY !== 1'b0 || STALL !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'd0) begin
      bad++;
      $display("FAIL reset_async: busy=%b stall=%b done=%b result=%h, required 0 0 0 00000000",
               BUSY, STALL, DONE, RESULT);
    end
    @(negedge CLK);
    RST = 1'b0;
    a = $urandom;
    b = $urandom | 32'h1;
    exp_v = ref_model(3'd3, a, b);
    run_op(3'd3, a, b, res, lat, stalls, got);
    total++;
    if (!got || res !== exp_v || lat != 34) begin
      bad++;
      $display("FAIL reset_recover: got=%b result %h latency %0d, required %h at 34", got, res, lat, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
